lat_data_memory: RTL

Parametrised, byte-addressed unified instruction/data memory for the RV32 core. The instruction port is a registered word read. The data port uses a request/ready/response handshake with a programmable access latency. Load sign/zero extension, byte-lane placement and misalignment/range error detection are done inside the block. It replaces the fixed single-cycle memory so the core's load/store unit can be exercised against multi-cycle, SRAM-like timing.

---
 rtl/lat_data_memory.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lat_data_memory.sv
// lat_data_memory: byte-addressed unified instruction/data memory.
// Instruction port: registered word read, one cycle, independent of the data port.
// Data port: request/ready/response handshake with a programmable access latency.
//
// Handshake: a request is accepted on a rising edge where d_req=1 and d_ready=1.
// Request inputs are ignored while d_ready=0, so the requester holds them until
// it sees d_ready. Every accepted request produces exactly one d_rvalid pulse.
// d_rdata and d_err are meaningful only while d_rvalid=1. They hold their values
// until the next commit.
module lat_data_memory #(
  parameter int SIZE    = 65536,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_ctrl,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(SIZE);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [7:0] mem [0:SIZE-1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit;

  logic        req_we_q;
  logic [3:0]  req_ctrl_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;

  // Access fields in effect at the commit edge.
  logic        a_we;
  logic [3:0]  a_ctrl;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic        size_onehot;
  logic        misaligned;
  logic        out_of_range;
  logic        a_err;
  logic [32:0] a_size;
  logic [32:0] a_end;

  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   ld_data;

  logic [AW-1:0] iw;
  logic          unused_iaddr;

  assign unused_iaddr = ^i_addr[1:0];
  assign dbg_state    = state_q;

  // FSM next-state, counter and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    d_ready  = 1'b1;
    d_rvalid = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        d_ready  = 1'b1;
        d_rvalid = (state_q == RESP);
        if (d_req) begin
          if (LAT_M1 == 4'd0) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        d_ready = 1'b0;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_ctrl_q  <= 4'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
    end else if (d_ready && d_req) begin
      req_we_q    <= d_we;
      req_ctrl_q  <= d_ctrl;
      req_addr_q  <= d_addr;
      req_wdata_q <= d_wdata;
    end
  end

  // With LATENCY=1 the commit happens on the accept edge, so the live inputs
  // are used; otherwise the captured request is committed from BUSY.
  always_comb begin
    if (state_q == BUSY) begin
      a_we    = req_we_q;
      a_ctrl  = req_ctrl_q;
      a_addr  = req_addr_q;
      a_wdata = req_wdata_q;
    end else begin
      a_we    = d_we;
      a_ctrl  = d_ctrl;
      a_addr  = d_addr;
      a_wdata = d_wdata;
    end
  end

  // Error detection: size encoding, alignment and range.
  always_comb begin
    size_onehot  = (a_ctrl[2:0] == 3'b001) || (a_ctrl[2:0] == 3'b010) ||
                   (a_ctrl[2:0] == 3'b100);
    misaligned   = (a_ctrl[1] && a_addr[0]) || (a_ctrl[2] && (a_addr[1:0] != 2'b00));
    if (a_ctrl[2])      a_size = 33'd4;
    else if (a_ctrl[1]) a_size = 33'd2;
    else                a_size = 33'd1;
    a_end        = {1'b0, a_addr} + a_size;
    out_of_range = a_end > 33'(SIZE);
    a_err        = !size_onehot || misaligned || out_of_range;
  end

  // Byte lanes of the data access and load extension.
  always_comb begin
    idx0 = a_addr[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    b0   = mem[idx0];
    b1   = mem[idx1];
    b2   = mem[idx2];
    b3   = mem[idx3];
    if (a_ctrl[0])      ld_data = {{24{a_ctrl[3] & b0[7]}}, b0};
    else if (a_ctrl[1]) ld_data = {{16{a_ctrl[3] & b1[7]}}, b1, b0};
    else                ld_data = {b3, b2, b1, b0};
  end

  // Response registers, updated only at the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rdata <= 32'd0;
      d_err   <= 1'b0;
    end else if (commit) begin
      d_err   <= a_err;
      d_rdata <= (a_err || a_we) ? 32'd0 : ld_data;
    end
  end

  // Store commit; contents are never cleared and reset blocks any write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && a_we && !a_err) begin
      mem[idx0] <= a_wdata[7:0];
      if (a_ctrl[1] || a_ctrl[2]) begin
        mem[idx1] <= a_wdata[15:8];
      end
      if (a_ctrl[2]) begin
        mem[idx2] <= a_wdata[23:16];
        mem[idx3] <= a_wdata[31:24];
      end
    end
  end

  assign iw = i_addr[AW-1:0] & ~AW'(3);

  // Instruction fetch; reads the pre-store contents on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= 32'd0;
    end else if (|i_addr[31:AW]) begin
      i_rdata <= 32'd0;
    end else begin
      i_rdata <= {mem[iw + AW'(3)], mem[iw + AW'(2)], mem[iw + AW'(1)], mem[iw]};
    end
  end

endmodule
